// File: rtl/rx_chan_packer.sv
// Receive channel packer: snapshots one sample set per strobe and streams it out
// as 16-bit words (one 16-bit or two rounded 8-bit samples), framed into packets.
module rx_chan_packer #(
   parameter int MAX_CH    = 8,
   parameter int PKT_WORDS = 256,
   parameter int OVR_W     = 16
) (
   input  logic                  rxclk,
   input  logic                  reset,
   input  logic                  rxstrobe,
   input  logic [16*MAX_CH-1:0]  ch_data,
   input  logic [4:0]            channels,
   input  logic                  mode_8bit,
   output logic [15:0]           out_data,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic                  out_last,
   input  logic                  clear_status,
   output logic                  rx_overrun,
   output logic [OVR_W-1:0]      overrun_count,
   output logic                  busy
);

   localparam int              PKT_W    = (PKT_WORDS > 1) ? $clog2(PKT_WORDS) : 1;
   localparam logic [PKT_W-1:0] PKT_LAST = PKT_W'(PKT_WORDS - 1);
   localparam logic [4:0]      MAX_CH_5 = 5'(MAX_CH);

   typedef enum logic {IDLE = 1'b0, SHIFT = 1'b1} state_t;

   state_t                state_r, state_nxt_s;
   logic [16*MAX_CH-1:0]  snap_r, snap_nxt_s;
   logic [4:0]            ch_cnt_r, ch_nxt_s, idx_r, idx_nxt_s;
   logic                  mode_r, mode_nxt_s;
   logic [PKT_W-1:0]      pkt_r, pkt_nxt_s;
   logic [15:0]           data_r, data_nxt_s;
   logic                  last_r, last_nxt_s, ovr_r, ovr_nxt_s;
   logic [OVR_W-1:0]      ovr_cnt_r, ovr_cnt_nxt_s;
   logic [4:0]            ch_clamp_s, n_words_s, last_idx_s;
   logic                  xfer_s, final_s, strobe_ok_s, accept_s, overrun_s;

   // Round toward zero: negative values with a nonzero low byte move up by one LSB.
   function automatic logic [7:0] round8(input logic [15:0] x);
      return x[15:8] + {7'b0000000, x[15] & (|x[7:0])};
   endfunction

   function automatic logic [15:0] pick(input logic [16*MAX_CH-1:0] snap, input logic [5:0] sel);
      logic [15:0] w;
      w = 16'h0000;
      for (int i = 0; i < MAX_CH; i++) begin
         if (sel == 6'(i)) w = snap[16*i +: 16];
      end
      return w;
   endfunction

   function automatic logic [15:0] word_of(input logic [16*MAX_CH-1:0] snap, input logic [4:0] ch,
                                           input logic mode, input logic [4:0] idx);
      logic [7:0] hi;
      if (mode) begin
         hi = ({idx, 1'b1} < {1'b0, ch}) ? round8(pick(snap, {idx, 1'b1})) : 8'h00;
         return {hi, round8(pick(snap, {idx, 1'b0}))};
      end
      return pick(snap, {1'b0, idx});
   endfunction

   assign ch_clamp_s  = (channels > MAX_CH_5) ? MAX_CH_5 : channels;
   assign n_words_s   = mode_r ? ((ch_cnt_r + 5'd1) >> 1) : ch_cnt_r;
   assign last_idx_s  = n_words_s - 5'd1;
   assign xfer_s      = (state_r == SHIFT) & out_ready;
   assign final_s     = xfer_s & (idx_r == last_idx_s);
   assign strobe_ok_s = rxstrobe & (channels != 5'd0);
   assign accept_s    = strobe_ok_s & ((state_r == IDLE) | final_s);
   assign overrun_s   = strobe_ok_s & (state_r == SHIFT) & ~final_s;

   // State register
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) state_r <= IDLE;
      else       state_r <= state_nxt_s;
   end

   // Next-state logic; a strobe on the final transfer chains straight into a new frame
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         IDLE:    if (accept_s) state_nxt_s = SHIFT; else state_nxt_s = IDLE;
         SHIFT:   if (final_s & ~accept_s) state_nxt_s = IDLE; else state_nxt_s = SHIFT;
         default: state_nxt_s = IDLE;
      endcase
   end

   // Output and datapath next values; outputs are precomputed so they leave a register
   always_comb begin
      snap_nxt_s = snap_r;
      ch_nxt_s   = ch_cnt_r;
      mode_nxt_s = mode_r;
      idx_nxt_s  = idx_r;
      if (accept_s) begin
         snap_nxt_s = ch_data;
         ch_nxt_s   = ch_clamp_s;
         mode_nxt_s = mode_8bit;
         idx_nxt_s  = 5'd0;
      end else if (final_s) begin
         idx_nxt_s = 5'd0;
      end else if (xfer_s) begin
         idx_nxt_s = idx_r + 5'd1;
      end else begin
         idx_nxt_s = idx_r;
      end
      if (xfer_s) pkt_nxt_s = (pkt_r == PKT_LAST) ? {PKT_W{1'b0}} : pkt_r + PKT_W'(1);
      else        pkt_nxt_s = pkt_r;
      if (clear_status) begin
         ovr_nxt_s     = overrun_s;
         ovr_cnt_nxt_s = overrun_s ? OVR_W'(1) : {OVR_W{1'b0}};
      end else if (overrun_s) begin
         ovr_nxt_s     = 1'b1;
         ovr_cnt_nxt_s = (&ovr_cnt_r) ? ovr_cnt_r : ovr_cnt_r + OVR_W'(1);
      end else begin
         ovr_nxt_s     = ovr_r;
         ovr_cnt_nxt_s = ovr_cnt_r;
      end
      if (state_nxt_s == SHIFT) begin
         data_nxt_s = word_of(snap_nxt_s, ch_nxt_s, mode_nxt_s, idx_nxt_s);
         last_nxt_s = (pkt_nxt_s == PKT_LAST);
      end else begin
         data_nxt_s = 16'h0000;
         last_nxt_s = 1'b0;
      end
   end

   // Datapath and status registers
   always_ff @(posedge rxclk or posedge reset) begin
      if (reset) begin
         snap_r    <= {(16*MAX_CH){1'b0}};
         ch_cnt_r  <= 5'd0;
         mode_r    <= 1'b0;
         idx_r     <= 5'd0;
         pkt_r     <= {PKT_W{1'b0}};
         data_r    <= 16'h0000;
         last_r    <= 1'b0;
         ovr_r     <= 1'b0;
         ovr_cnt_r <= {OVR_W{1'b0}};
      end else begin
         snap_r    <= snap_nxt_s;
         ch_cnt_r  <= ch_nxt_s;
         mode_r    <= mode_nxt_s;
         idx_r     <= idx_nxt_s;
         pkt_r     <= pkt_nxt_s;
         data_r    <= data_nxt_s;
         last_r    <= last_nxt_s;
         ovr_r     <= ovr_nxt_s;
         ovr_cnt_r <= ovr_cnt_nxt_s;
      end
   end

   assign out_valid     = (state_r == SHIFT);
   assign busy          = (state_r == SHIFT);
   assign out_data      = data_r;
   assign out_last      = last_r;
   assign rx_overrun    = ovr_r;
   assign overrun_count = ovr_cnt_r;

endmodule
